rr_credit_dispatcher: RTL and testbench
=======================================

// Module: rr_credit_dispatcher
// PURPOSE
//  Round-robin load-balancing dispatcher. Accepts requests on one valid/ready input.
//  Forwards each request to one of NUM_WORKERS worker ports.
//  Each worker has a saturating credit counter that limits its outstanding requests.
//  Sits between the ingress stream and the worker array; the rotation pointer is a
//  wrapping up-counter (0..NUM_WORKERS-1) and credits are bounded counters.
// PARAMETERS
//  NUM_WORKERS  4   number of worker ports (>=2)
//  DATA_BITS    32  request payload width
//  MAX_CREDITS  5   outstanding requests allowed per worker (>=1)
//  CREDIT_BITS  3   credit counter width; must hold MAX_CREDITS
//  PTR_BITS     2   rotation pointer width = $clog2(NUM_WORKERS)
// PORTS
//  clk        in   1                        clock, all state on rising edge
//  resetn     in   1                        asynchronous reset, active-low
//  enable     in   1                        1 = new requests may be accepted
//  in_valid   in   1                        request present
//  in_data    in   DATA_BITS                request payload
//  in_ready   out  1                        request accepted when in_valid&in_ready
//  out_valid  out  NUM_WORKERS              one-hot: request offered to worker i
//  out_data   out  DATA_BITS                payload, shared by all workers
//  out_ready  in   NUM_WORKERS              worker i takes the offer
//  done       in   NUM_WORKERS              1-cycle pulse: worker i finished; return 1 credit
//  credits    out  NUM_WORKERS*CREDIT_BITS  credit count of worker i in slice i
//  grant_ptr  out  PTR_BITS                 next worker searched first
//  all_busy   out  1                        every credit counter is 0
//  credit_err out  1                        sticky: done seen while credit==MAX_CREDITS
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - out_valid=0, out_data=0, grant_ptr=0, credit_err=0.
//   - Every credit = MAX_CREDITS.
//   - State=IDLE. An offer in flight is dropped.
//  States:
//   - IDLE: no offer.
//   - OFFER: out_valid[sel] held high, with out_data and sel stable, until out_ready[sel]=1.
//  Offer completion:
//   - xfer = OFFER & out_ready[sel].
//   - Only out_ready[sel] counts; out_ready of other bits is ignored.
//  Selection (combinational):
//   - sel_next = first i, scanning grant_ptr, grant_ptr+1, ... mod NUM_WORKERS, with credit[i]>0.
//   - Credit values used are the register values; same-cycle done is not counted.
//  Input ready:
//   - in_ready = enable & ~all_busy & (IDLE | xfer).
//   - Allows back-to-back: 1 request/cycle when the worker is ready.
//  On accept:
//   - Register in_data into out_data; sel <= sel_next.
//   - Next cycle out_valid = onehot(sel_next), state=OFFER. Latency 1 cycle.
//   - grant_ptr <= sel_next+1; wraps NUM_WORKERS-1 -> 0.
//   - credit[sel_next] decrements.
//  On xfer without accept: state -> IDLE, out_valid -> 0.
//  Credit update per worker i, same edge:
//   - Decrement only (accept to i): credit-1.
//   - done[i] only: credit+1.
//   - Both: unchanged.
//   - done[i] at credit==MAX_CREDITS with no decrement: credit holds, credit_err <= 1.
//   - Credit never underflows, because selection requires credit>0.
//  all_busy: registered-credit OR-reduce, inverted. grant_ptr does not move while idle.
//  enable=0 blocks new accepts only; a pending OFFER still completes. done still returns credits.
// TESTING (NUM_WORKERS=4, MAX_CREDITS=2, DATA_BITS=8)
//  1. Reset, hold in_valid=1 with data 1,2,3,4, all out_ready=1, no done
//     -> out_valid 0001,0010,0100,1000 on consecutive cycles.
//     -> grant_ptr wraps 1,2,3,0; out_data matches the sequence.
//  2. Continue without done
//     -> 4 more dispatches, then all credits 0, all_busy=1, in_ready=0.
//     -> Pulse done[2] -> next request goes to worker 2 only.
//  3. Credits {2,0,2,2}, grant_ptr=1 -> request skips worker 1 and goes to worker 2.
//     -> grant_ptr=3.
//  4. out_ready[sel]=0 for 3 cycles
//     -> out_valid/out_data stable and in_ready=0; other out_ready bits ignored.
//     -> Raising out_ready[sel] with in_valid=1 gives xfer+accept on the same edge.
//  5. done[0] on the same edge as accept to worker 0 -> credit[0] unchanged.
//     -> Extra done[0] at credit 2 -> credit stays 2, credit_err=1 until reset.
//  6. enable=0 during OFFER -> offer completes, then in_ready=0.
//     -> resetn=0 mid-OFFER -> out_valid=0 immediately, credits=2, grant_ptr=0.

Source files
------------

// File: rtl/rr_credit_dispatcher.sv
// Round-robin dispatcher: forwards each ingress request to the next worker that still has credit.
// Latency: one cycle from accept to out_valid; credits and the pointer update on the accept edge.
// Backpressure: in_ready drops while an offer waits on out_ready[sel], while disabled, or when every worker is out of credit.
module rr_credit_dispatcher #(
    parameter int NUM_WORKERS = 4,
    parameter int DATA_BITS   = 32,
    parameter int MAX_CREDITS = 5,
    parameter int CREDIT_BITS = 3,
    parameter int PTR_BITS    = 2
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               enable,
    input  logic                               in_valid,
    input  logic [DATA_BITS-1:0]               in_data,
    output logic                               in_ready,
    output logic [NUM_WORKERS-1:0]             out_valid,
    output logic [DATA_BITS-1:0]               out_data,
    input  logic [NUM_WORKERS-1:0]             out_ready,
    input  logic [NUM_WORKERS-1:0]             done,
    output logic [NUM_WORKERS*CREDIT_BITS-1:0] credits,
    output logic [PTR_BITS-1:0]                grant_ptr,
    output logic                               all_busy,
    output logic                               credit_err
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    localparam logic [CREDIT_BITS-1:0] CRED_MAX = CREDIT_BITS'(MAX_CREDITS);
    localparam logic [PTR_BITS-1:0]    PTR_LAST = PTR_BITS'(NUM_WORKERS - 1);

    logic [0:0]             state;
    logic [PTR_BITS-1:0]    sel;
    logic [PTR_BITS-1:0]    sel_next;
    logic [PTR_BITS-1:0]    ptr_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   err_q;
    logic [CREDIT_BITS-1:0] credit [NUM_WORKERS];

    logic [NUM_WORKERS-1:0] credit_nz;
    logic [NUM_WORKERS-1:0] dec;
    logic [PTR_BITS-1:0]    pick_hi;
    logic [PTR_BITS-1:0]    pick_lo;
    logic                   found_hi;
    logic                   found_lo;
    logic                   xfer;
    logic                   accept;

    // Rotating priority: first worker with credit at or above the pointer, else first below it.
    always_comb begin
        credit_nz = '0;
        pick_hi   = '0;
        pick_lo   = '0;
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            credit_nz[i] = (credit[i] != '0);
            if (credit_nz[i] && (PTR_BITS'(i) >= ptr_q) && !found_hi) begin
                pick_hi  = PTR_BITS'(i);
                found_hi = 1'b1;
            end
            if (credit_nz[i] && (PTR_BITS'(i) < ptr_q) && !found_lo) begin
                pick_lo  = PTR_BITS'(i);
                found_lo = 1'b1;
            end
        end
        sel_next = found_hi ? pick_hi : pick_lo;
    end

    assign all_busy = ~|credit_nz;
    assign xfer     = (state == ST_OFFER) && out_ready[sel];
    assign in_ready = enable && !all_busy && ((state == ST_IDLE) || xfer);
    assign accept   = in_valid && in_ready;

    // One-hot offer to the selected worker, and the per-worker decrement strobe.
    always_comb begin
        out_valid = '0;
        dec       = '0;
        if (state == ST_OFFER) begin
            out_valid[sel] = 1'b1;
        end
        for (int i = 0; i < NUM_WORKERS; i++) begin
            dec[i] = accept && (sel_next == PTR_BITS'(i));
        end
    end

    // Offer state, captured payload, target worker and rotation pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            sel    <= '0;
            data_q <= '0;
            ptr_q  <= '0;
        end else if (accept) begin
            state  <= ST_OFFER;
            sel    <= sel_next;
            data_q <= in_data;
            ptr_q  <= (sel_next == PTR_LAST) ? '0 : sel_next + PTR_BITS'(1);
        end else if (xfer) begin
            state  <= ST_IDLE;
        end
    end

    // Credit counters: accept takes one, done returns one, both together cancel; overflow is flagged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
            for (int i = 0; i < NUM_WORKERS; i++) begin
                credit[i] <= CRED_MAX;
            end
        end else begin
            for (int i = 0; i < NUM_WORKERS; i++) begin
                if (dec[i] && !done[i]) begin
                    credit[i] <= credit[i] - CREDIT_BITS'(1);
                end else if (done[i] && !dec[i]) begin
                    if (credit[i] == CRED_MAX) begin
                        err_q <= 1'b1;
                    end else begin
                        credit[i] <= credit[i] + CREDIT_BITS'(1);
                    end
                end
            end
        end
    end

    // Flatten the counters into the packed status bus, worker i in slice i.
    always_comb begin
        credits = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            credits[i*CREDIT_BITS +: CREDIT_BITS] = credit[i];
        end
    end

    assign out_data   = data_q;
    assign grant_ptr  = ptr_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_rr_credit_dispatcher.sv
module tb_rr_credit_dispatcher;

    localparam int NW   = 4;
    localparam int DB   = 8;
    localparam int MAXC = 2;
    localparam int CB   = 2;
    localparam int PB   = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          enable;
    logic          in_valid;
    logic [DB-1:0] in_data;
    logic          in_ready;
    logic [NW-1:0] out_valid;
    logic [DB-1:0] out_data;
    logic [NW-1:0] out_ready;
    logic [NW-1:0] done;
    logic [NW*CB-1:0] credits;
    logic [PB-1:0] grant_ptr;
    logic          all_busy;
    logic          credit_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    rr_credit_dispatcher #(
        .NUM_WORKERS(NW), .DATA_BITS(DB), .MAX_CREDITS(MAXC),
        .CREDIT_BITS(CB), .PTR_BITS(PB)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .done(done), .credits(credits), .grant_ptr(grant_ptr),
        .all_busy(all_busy), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pending offer is (m_busy, m_sel, m_data); credits are plain integers.
    int          m_cred [NW];
    int          m_ptr;
    bit          m_busy;
    int          m_sel;
    logic [DB-1:0] m_data;
    bit          m_err;

    function automatic int pick_worker();
        for (int k = 0; k < NW; k++) begin
            if (m_cred[(m_ptr + k) % NW] > 0) return (m_ptr + k) % NW;
        end
        return -1;
    endfunction

    function automatic bit m_all_busy();
        for (int i = 0; i < NW; i++) if (m_cred[i] > 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_in_ready();
        return enable && !m_all_busy() && (!m_busy || out_ready[m_sel]);
    endfunction

    function automatic bit m_accept();
        return in_valid && m_in_ready();
    endfunction

    function automatic int raw_next(input int i);
        int v;
        v = m_cred[i] + int'(done[i]);
        if (m_accept() && pick_worker() == i) v = v - 1;
        return v;
    endfunction

    function automatic int next_cred(input int i);
        return (raw_next(i) > MAXC) ? MAXC : raw_next(i);
    endfunction

    function automatic bit any_overflow();
        for (int i = 0; i < NW; i++) if (raw_next(i) > MAXC) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NW-1:0] m_out_valid();
        logic [NW-1:0] v;
        v = '0;
        if (m_busy) v[m_sel] = 1'b1;
        return v;
    endfunction

    function automatic logic [NW*CB-1:0] m_credits();
        logic [NW*CB-1:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) v[i*CB +: CB] = CB'(m_cred[i]);
        return v;
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NW; i++) m_cred[i] <= MAXC;
            m_ptr  <= 0;
            m_busy <= 1'b0;
            m_sel  <= 0;
            m_data <= '0;
            m_err  <= 1'b0;
        end else begin
            if (m_accept()) begin
                m_busy <= 1'b1;
                m_sel  <= pick_worker();
                m_data <= in_data;
                m_ptr  <= (pick_worker() + 1) % NW;
            end else if (m_busy && out_ready[m_sel]) begin
                m_busy <= 1'b0;
            end
            for (int i = 0; i < NW; i++) m_cred[i] <= next_cred(i);
            if (any_overflow()) m_err <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid",  32'(out_valid),  32'(m_out_valid()));
            chk("out_data",   32'(out_data),   32'(m_data));
            chk("in_ready",   32'(in_ready),   32'(m_in_ready()));
            chk("credits",    32'(credits),    32'(m_credits()));
            chk("grant_ptr",  32'(grant_ptr),  32'(m_ptr));
            chk("all_busy",   32'(all_busy),   32'(m_all_busy()));
            chk("credit_err", 32'(credit_err), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0; done = '0;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_credits",   32'(credits),   32'hAA);
        chk("rst_ptr",       32'(grant_ptr), 32'h0);
        chk("rst_err",       32'(credit_err), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk_en = 1'b1;
        resetn = 1'b1;

        // Rotation through all workers, one per cycle.
        enable = 1'b1; in_valid = 1'b1; out_ready = 4'hF; in_data = 8'd1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_valid", 32'(out_valid), 32'(1 << k));
            chk("t1_data",  32'(out_data),  32'(k + 1));
            chk("t1_ptr",   32'(grant_ptr), 32'((k + 1) % 4));
            in_data = 8'(k + 2);
        end
        chk("t1_credits", 32'(credits), 32'h55);

        // Exhaust credits, then one done re-opens worker 2 only.
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_valid", 32'(out_valid), 32'(1 << k));
            chk("t2_data",  32'(out_data),  32'(k + 5));
            in_data = 8'(k + 6);
        end
        chk("t2_credits", 32'(credits),  32'h00);
        chk("t2_busy",    32'(all_busy), 32'h1);
        chk("t2_ready",   32'(in_ready), 32'h0);
        done = 4'b0100;
        step();
        done = 4'b0000;
        chk("t2_idle", 32'(out_valid), 32'h0);
        step();
        chk("t2_w2",     32'(out_valid), 32'h4);
        chk("t2_w2data", 32'(out_data),  32'h9);
        chk("t2_ptr",    32'(grant_ptr), 32'h3);

        // Skip a worker with no credit.
        in_valid = 1'b0; done = 4'b1101;
        step();
        step();
        done = 4'b0000;
        chk("t3_credits", 32'(credits), 32'hA2);
        in_valid = 1'b1; in_data = 8'hA0;
        step();
        in_data = 8'hA1;
        step();
        in_valid = 1'b0; done = 4'b1001;
        step();
        done = 4'b0000;
        chk("t3_setup_ptr", 32'(grant_ptr), 32'h1);
        chk("t3_setup_cr",  32'(credits),   32'hA2);
        in_valid = 1'b1; in_data = 8'hA2;
        step();
        in_valid = 1'b0;
        chk("t3_skip", 32'(out_valid), 32'h4);
        chk("t3_ptr",  32'(grant_ptr), 32'h3);

        // Stalled offer ignores the other workers' ready bits.
        out_ready = 4'b1011; in_valid = 1'b1; in_data = 8'hB0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_valid", 32'(out_valid), 32'h4);
            chk("t4_hold_data",  32'(out_data),  32'hA2);
            chk("t4_hold_ready", 32'(in_ready),  32'h0);
        end
        out_ready = 4'b0100;
        #1;
        chk("t4_xfer_ready", 32'(in_ready), 32'h1);
        step();
        chk("t4_next_valid", 32'(out_valid), 32'h8);
        chk("t4_next_data",  32'(out_data),  32'hB0);
        in_valid = 1'b0; out_ready = 4'hF;
        step();

        // done coinciding with accept, then done at full credit.
        in_valid = 1'b1; in_data = 8'hC0; done = 4'b0001;
        step();
        in_valid = 1'b0; done = 4'b0000;
        chk("t5_cr0",   32'(credits[1:0]), 32'h2);
        chk("t5_valid", 32'(out_valid),    32'h1);
        chk("t5_err0",  32'(credit_err),   32'h0);
        done = 4'b0001;
        step();
        done = 4'b0000;
        chk("t5_cr0_sat", 32'(credits[1:0]), 32'h2);
        chk("t5_err1",    32'(credit_err),   32'h1);
        step();
        step();
        chk("t5_err_sticky", 32'(credit_err), 32'h1);

        // enable low lets the offer finish but blocks new work; reset mid-offer.
        out_ready = 4'h0; in_valid = 1'b1; in_data = 8'hD0;
        step();
        enable = 1'b0;
        #1;
        chk("t6_valid",  32'(out_valid), 32'h4);
        chk("t6_ready0", 32'(in_ready),  32'h0);
        step();
        out_ready = 4'hF;
        step();
        chk("t6_done_valid", 32'(out_valid), 32'h0);
        chk("t6_ready1",     32'(in_ready),  32'h0);
        enable = 1'b1;
        step();
        out_ready = 4'h0;
        chk("t6_offer", 32'(out_valid), 32'h8);
        #1 resetn = 1'b0;
        #1;
        chk("t6_rst_valid",   32'(out_valid),  32'h0);
        chk("t6_rst_credits", 32'(credits),    32'hAA);
        chk("t6_rst_ptr",     32'(grant_ptr),  32'h0);
        chk("t6_rst_err",     32'(credit_err), 32'h0);
        step();
        resetn = 1'b1;

        // Randomised traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            for (int i = 0; i < NW; i++) done[i] = ($urandom_range(0, 4) == 0);
            if (n % 1000 == 999) resetn = 1'b0;
            step();
            resetn = 1'b1;
        end
        done = '0; in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
